// File: rtl/dram_mux_sequencer.sv
// -----------------------------------------------------------------------------
// dram_mux_sequencer
//
// Sequences the 74F257 row/column address multiplexers and the DRAM strobes
// for chip-RAM accesses. Arbitrates between a DMA and a CPU requester
// (round-robin when both ask at once) and inserts periodic CAS-before-RAS
// refresh. Every output is registered: the next-state logic also decodes
// the strobe values for the state being entered, so they change on the same
// edge as the state register.
//
// Ports
//   CLK, RESET          clock; synchronous active-high reset
//   dma_req/addr/we     DMA request (level), address, write enable
//   dma_ack             one-cycle pulse in the last CAS cycle of a DMA access
//   cpu_req/addr/we/ack same as dma_*, for the CPU port
//   row_addr, col_addr  upper / lower address halves to mux I0 / I1 inputs
//   mux_S               mux select: 0 = row (I0), 1 = column (I1)
//   mux_nOE             mux output enable, active low
//   nRAS, nCAS, nWE     DRAM strobes, active low
//   refresh_overrun     sticky: refresh came due while one was still pending
// -----------------------------------------------------------------------------
module dram_mux_sequencer #(
    parameter int ADDR_W         = 18,
    parameter int CAS_CYCLES     = 2,
    parameter int PRE_CYCLES     = 2,
    parameter int REFRESH_PERIOD = 128
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                dma_req,
    input  logic [ADDR_W-1:0]   dma_addr,
    input  logic                dma_we,
    output logic                dma_ack,
    input  logic                cpu_req,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic                cpu_we,
    output logic                cpu_ack,
    output logic [ADDR_W/2-1:0] row_addr,
    output logic [ADDR_W/2-1:0] col_addr,
    output logic                mux_S,
    output logic                mux_nOE,
    output logic                nRAS,
    output logic                nCAS,
    output logic                nWE,
    output logic                refresh_overrun
);

    localparam int HALF_W = ADDR_W / 2;
    localparam int PH_MAX = (CAS_CYCLES > PRE_CYCLES) ? CAS_CYCLES : PRE_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int RT_W   = $clog2(REFRESH_PERIOD);

    localparam logic [PH_W-1:0] CAS_LOAD  = PH_W'(CAS_CYCLES - 1);
    localparam logic [PH_W-1:0] PRE_LOAD  = PH_W'(PRE_CYCLES - 1);
    localparam logic [PH_W-1:0] REF_LOAD  = PH_W'(1);
    localparam logic [RT_W-1:0] RT_RELOAD = RT_W'(REFRESH_PERIOD - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ROW, ST_RAS, ST_SWITCH, ST_CAS, ST_PRE, ST_REF_CAS, ST_REF_RAS
    } state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] ph_q, ph_d;        // cycles left in multi-cycle states
    port_t           port_q;            // port owning the current access
    port_t           last_q;            // port of the most recent grant
    logic            we_q;
    logic            pend_q;
    logic [RT_W-1:0] rtmr_q;

    logic            grant, grant_dma, enter_ref, expire;
    logic [ADDR_W-1:0] grant_addr;
    logic            mux_nOE_d, mux_S_d, nRAS_d, nCAS_d, nWE_d, dma_ack_d, cpu_ack_d;

    // A pending refresh always beats a waiting request.
    assign enter_ref  = (state_q == ST_IDLE) && pend_q;
    assign grant      = (state_q == ST_IDLE) && !pend_q && (dma_req || cpu_req);
    // DMA wins a tie unless it also won the previous grant.
    assign grant_dma  = dma_req && (!cpu_req || (last_q == PORT_CPU));
    assign grant_addr = grant_dma ? dma_addr : cpu_addr;
    assign expire     = (rtmr_q == '0);

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;

        unique case (state_q)
            ST_IDLE: begin
                if (enter_ref)  state_d = ST_REF_CAS;
                else if (grant) state_d = ST_ROW;
            end
            ST_ROW:    state_d = ST_RAS;
            ST_RAS:    state_d = ST_SWITCH;
            ST_SWITCH: begin
                state_d = ST_CAS;
                ph_d    = CAS_LOAD;
            end
            ST_CAS: begin
                if (ph_q == '0) begin
                    state_d = ST_PRE;
                    ph_d    = PRE_LOAD;
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            ST_PRE: begin
                if (ph_q == '0) state_d = ST_IDLE;
                else            ph_d    = ph_q - PH_W'(1);
            end
            ST_REF_CAS: begin
                state_d = ST_REF_RAS;
                ph_d    = REF_LOAD;
            end
            ST_REF_RAS: begin
                if (ph_q == '0) begin
                    state_d = ST_PRE;
                    ph_d    = PRE_LOAD;
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobe values for the state being entered; registered below.
        mux_nOE_d = !(state_d inside {ST_ROW, ST_RAS, ST_SWITCH, ST_CAS});
        mux_S_d   =   state_d inside {ST_SWITCH, ST_CAS};
        nRAS_d    = !(state_d inside {ST_RAS, ST_SWITCH, ST_CAS, ST_REF_RAS});
        nCAS_d    = !(state_d inside {ST_CAS, ST_REF_CAS, ST_REF_RAS});
        nWE_d     = !((state_d == ST_CAS) && we_q);
        dma_ack_d = (state_d == ST_CAS) && (ph_d == '0) && (port_q == PORT_DMA);
        cpu_ack_d = (state_d == ST_CAS) && (ph_d == '0) && (port_q == PORT_CPU);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q         <= ST_IDLE;
            ph_q            <= '0;
            port_q          <= PORT_CPU;
            last_q          <= PORT_CPU;
            we_q            <= 1'b0;
            pend_q          <= 1'b0;
            rtmr_q          <= RT_RELOAD;
            refresh_overrun <= 1'b0;
            row_addr        <= '0;
            col_addr        <= '0;
            mux_nOE         <= 1'b1;
            mux_S           <= 1'b0;
            nRAS            <= 1'b1;
            nCAS            <= 1'b1;
            nWE             <= 1'b1;
            dma_ack         <= 1'b0;
            cpu_ack         <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;

            if (grant) begin
                row_addr <= grant_addr[ADDR_W-1:HALF_W];
                col_addr <= grant_addr[HALF_W-1:0];
                we_q     <= grant_dma ? dma_we : cpu_we;
                port_q   <= grant_dma ? PORT_DMA : PORT_CPU;
                last_q   <= grant_dma ? PORT_DMA : PORT_CPU;
            end

            // A new expiry outranks the clear from entering refresh, so a
            // refresh due on that same edge is not lost.
            if (expire) begin
                rtmr_q <= RT_RELOAD;
                pend_q <= 1'b1;
                if (pend_q) refresh_overrun <= 1'b1;
            end else begin
                rtmr_q <= rtmr_q - RT_W'(1);
                if (enter_ref) pend_q <= 1'b0;
            end

            mux_nOE <= mux_nOE_d;
            mux_S   <= mux_S_d;
            nRAS    <= nRAS_d;
            nCAS    <= nCAS_d;
            nWE     <= nWE_d;
            dma_ack <= dma_ack_d;
            cpu_ack <= cpu_ack_d;
        end
    end

endmodule

// File: tb/tb_dram_mux_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dram_mux_sequencer
//
// Four instances of dram_mux_sequencer share clock, reset and requester
// inputs; each scenario watches the instance whose parameters it needs:
//   0: defaults, 1: REFRESH_PERIOD=16, 2: REFRESH_PERIOD=16 CAS_CYCLES=12,
//   3: CAS_CYCLES=1 PRE_CYCLES=1.
// Granted accesses are queued as expectations when a request is raised and
// popped when the matching ack pulse appears.
// -----------------------------------------------------------------------------
module tb_dram_mux_sequencer;

    localparam int ADDR_W = 18;
    localparam int HALF   = ADDR_W / 2;
    localparam int N      = 4;
    localparam int CAS_TAB [N] = '{2, 2, 12, 1};
    localparam int PRE_TAB [N] = '{2, 2, 2, 1};
    localparam int REF_TAB [N] = '{128, 16, 16, 128};

    // {mux_nOE, mux_S, nRAS, nCAS, nWE}
    localparam logic [4:0] S_IDLE = 5'b10111;

    typedef struct {
        bit              is_dma;
        logic [HALF-1:0] row;
        logic [HALF-1:0] col;
        logic            we;
    } exp_t;

    logic              CLK      = 1'b0;
    logic              RESET    = 1'b1;
    logic              dma_req  = 1'b0;
    logic              dma_we   = 1'b0;
    logic [ADDR_W-1:0] dma_addr = '0;
    logic              cpu_req  = 1'b0;
    logic              cpu_we   = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;

    logic [N-1:0]    dma_ack_v, cpu_ack_v, mux_S_v, mux_nOE_v;
    logic [N-1:0]    nRAS_v, nCAS_v, nWE_v, ovr_v;
    logic [HALF-1:0] row_v [N];
    logic [HALF-1:0] col_v [N];

    exp_t sb [$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dram_mux_sequencer #(
            .ADDR_W        (ADDR_W),
            .CAS_CYCLES    (CAS_TAB[g]),
            .PRE_CYCLES    (PRE_TAB[g]),
            .REFRESH_PERIOD(REF_TAB[g])
        ) u_dut (
            .CLK            (CLK),
            .RESET          (RESET),
            .dma_req        (dma_req),
            .dma_addr       (dma_addr),
            .dma_we         (dma_we),
            .dma_ack        (dma_ack_v[g]),
            .cpu_req        (cpu_req),
            .cpu_addr       (cpu_addr),
            .cpu_we         (cpu_we),
            .cpu_ack        (cpu_ack_v[g]),
            .row_addr       (row_v[g]),
            .col_addr       (col_v[g]),
            .mux_S          (mux_S_v[g]),
            .mux_nOE        (mux_nOE_v[g]),
            .nRAS           (nRAS_v[g]),
            .nCAS           (nCAS_v[g]),
            .nWE            (nWE_v[g]),
            .refresh_overrun(ovr_v[g])
        );
    end

    function automatic logic [4:0] strobes(int i);
        return {mux_nOE_v[i], mux_S_v[i], nRAS_v[i], nCAS_v[i], nWE_v[i]};
    endfunction

    function automatic logic [HALF-1:0] row_of(logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:HALF];
    endfunction

    function automatic logic [HALF-1:0] col_of(logic [ADDR_W-1:0] a);
        return a[HALF-1:0];
    endfunction

    // After the k-th tick following do_reset the bench observes cycle k.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET   = 1'b1;
        dma_req = 1'b0;
        cpu_req = 1'b0;
        sb.delete();
        repeat (2) tick();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET   = 1'b1;
        dma_req = 1'b0;
        cpu_req = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < N; i++) begin
            tests_run++;
            if (strobes(i) !== S_IDLE) begin
                tests_failed++;
                $display("FAIL reset_strobes[%0d]: got %b, expected %b", i, strobes(i), S_IDLE);
            end
            tests_run++;
            if ({dma_ack_v[i], cpu_ack_v[i], ovr_v[i]} !== 3'b000) begin
                tests_failed++;
                $display("FAIL reset_flags[%0d]: got %b, expected 000", i,
                         {dma_ack_v[i], cpu_ack_v[i], ovr_v[i]});
            end
            tests_run++;
            if ({row_v[i], col_v[i]} !== '0) begin
                tests_failed++;
                $display("FAIL reset_addr[%0d]: got %h/%h, expected 0/0", i, row_v[i], col_v[i]);
            end
        end
    endtask

    task automatic test_cpu_write();
        logic [4:0] tbl [8] = '{5'b00111, 5'b00011, 5'b01011, 5'b01000,
                                5'b01000, 5'b10111, 5'b10111, 5'b10111};
        exp_t e;
        do_reset();
        cpu_addr = 18'h2A5C3;
        cpu_we   = 1'b1;
        sb.push_back('{is_dma: 1'b0, row: row_of(cpu_addr), col: col_of(cpu_addr), we: 1'b1});
        cpu_req  = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            tests_run++;
            if (strobes(0) !== tbl[c-1]) begin
                tests_failed++;
                $display("FAIL write_strobes c%0d: got %b, expected %b", c, strobes(0), tbl[c-1]);
            end
            tests_run++;
            if ({dma_ack_v[0], cpu_ack_v[0]} !== {1'b0, c == 5}) begin
                tests_failed++;
                $display("FAIL write_ack c%0d: got %b, expected %b", c,
                         {dma_ack_v[0], cpu_ack_v[0]}, {1'b0, c == 5});
            end
            if (cpu_ack_v[0]) begin
                cpu_req = 1'b0;
                e = sb.pop_front();
                tests_run++;
                if ({row_v[0], col_v[0]} !== {e.row, e.col}) begin
                    tests_failed++;
                    $display("FAIL write_addr: got %h/%h, expected %h/%h",
                             row_v[0], col_v[0], e.row, e.col);
                end
            end
        end
        tests_run++;
        if ({row_v[0], col_v[0]} !== {row_of(18'h2A5C3), col_of(18'h2A5C3)}) begin
            tests_failed++;
            $display("FAIL idle_hold_addr: got %h/%h", row_v[0], col_v[0]);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   last_ack = -1;
        int   n_acks = 0;
        int   dma_left = 1;
        int   cpu_left = 1;
        bit   re_dma = 1'b0;
        bit   re_cpu = 1'b0;
        bit   is_dma;
        do_reset();
        dma_addr = 18'h12345; dma_we = 1'b1;
        cpu_addr = 18'h0ABCD; cpu_we = 1'b0;
        sb.push_back('{is_dma: 1'b1, row: row_of(dma_addr), col: col_of(dma_addr), we: 1'b1});
        sb.push_back('{is_dma: 1'b0, row: row_of(cpu_addr), col: col_of(cpu_addr), we: 1'b0});
        dma_req = 1'b1;
        cpu_req = 1'b1;
        for (int k = 1; k <= 80 && n_acks < 4; k++) begin
            tick();
            if (re_dma) begin dma_req = 1'b1; re_dma = 1'b0; end
            if (re_cpu) begin cpu_req = 1'b1; re_cpu = 1'b0; end
            tests_run++;
            if ((dma_ack_v[0] & cpu_ack_v[0]) !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_coincident c%0d: got both acks, expected at most one", k);
            end
            if (dma_ack_v[0] || cpu_ack_v[0]) begin
                is_dma = dma_ack_v[0];
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL b2b_unexpected_ack c%0d: got ack, expected none", k);
                end else begin
                    e = sb.pop_front();
                    tests_run++;
                    if (is_dma !== e.is_dma) begin
                        tests_failed++;
                        $display("FAIL b2b_order c%0d: got dma=%0b, expected dma=%0b", k, is_dma, e.is_dma);
                    end
                    tests_run++;
                    if ({row_v[0], col_v[0], nWE_v[0]} !== {e.row, e.col, ~e.we}) begin
                        tests_failed++;
                        $display("FAIL b2b_addr c%0d: got %h/%h/%b, expected %h/%h/%b", k,
                                 row_v[0], col_v[0], nWE_v[0], e.row, e.col, ~e.we);
                    end
                end
                if (last_ack >= 0) begin
                    tests_run++;
                    if (k - last_ack != 8) begin
                        tests_failed++;
                        $display("FAIL b2b_spacing: got %0d, expected 8", k - last_ack);
                    end
                end
                last_ack = k;
                n_acks++;
                if (is_dma) begin
                    dma_req = 1'b0;
                    if (dma_left > 0) begin
                        dma_left--;
                        dma_addr = 18'h2F00F; dma_we = 1'b0;
                        sb.push_back('{is_dma: 1'b1, row: row_of(dma_addr), col: col_of(dma_addr), we: 1'b0});
                        re_dma = 1'b1;
                    end
                end else begin
                    cpu_req = 1'b0;
                    if (cpu_left > 0) begin
                        cpu_left--;
                        cpu_addr = 18'h00F0F; cpu_we = 1'b1;
                        sb.push_back('{is_dma: 1'b0, row: row_of(cpu_addr), col: col_of(cpu_addr), we: 1'b1});
                        re_cpu = 1'b1;
                    end
                end
            end
        end
        tests_run++;
        if (n_acks != 4 || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d acks (%0d left), expected 4 (0 left)", n_acks, sb.size());
        end
        dma_req = 1'b0;
        cpu_req = 1'b0;
    endtask

    task automatic test_refresh();
        int         tmr = 15;
        bit         due = 1'b0;
        int         due_k = 0;
        int         refs = 0;
        int         phase = 0;
        logic [4:0] cur;
        logic [4:0] prev = S_IDLE;
        do_reset();
        cpu_addr = 18'h01234;
        cpu_we   = 1'b0;
        cpu_req  = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (tmr == 0) begin
                due = 1'b1; due_k = k; tmr = 15;
            end else begin
                tmr--;
            end
            cur = strobes(1);
            if (phase == 1 || phase == 2) begin
                tests_run++;
                if (cur !== 5'b10001) begin
                    tests_failed++;
                    $display("FAIL ref_ras c%0d: got %b, expected 10001", k, cur);
                end
                phase++;
            end else if (phase == 3) begin
                tests_run++;
                if (cur !== S_IDLE) begin
                    tests_failed++;
                    $display("FAIL ref_pre c%0d: got %b, expected %b", k, cur, S_IDLE);
                end
                phase = 0;
            end
            if (prev[1] && !cur[1] && cur[2]) begin
                tests_run++;
                if (cur !== 5'b10101 || !(due && k > due_k)) begin
                    tests_failed++;
                    $display("FAIL ref_start c%0d: got %b due=%0b, expected 10101 due=1", k, cur, due);
                end
                refs++;
                due   = 1'b0;
                phase = 1;
            end
            if (prev[4] && !cur[4]) begin
                tests_run++;
                if (due && k > due_k) begin
                    tests_failed++;
                    $display("FAIL ref_before_grant c%0d: got grant, expected refresh first", k);
                end
            end
            prev = cur;
        end
        tests_run++;
        if (refs < 5) begin
            tests_failed++;
            $display("FAIL ref_count: got %0d, expected at least 5", refs);
        end
        tests_run++;
        if (ovr_v[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ref_no_overrun: got %b, expected 0", ovr_v[1]);
        end
        cpu_req = 1'b0;
    endtask

    task automatic test_overrun();
        bit found = 1'b0;
        int drops = 0;
        do_reset();
        cpu_addr = 18'h3FFFF;
        cpu_we   = 1'b1;
        cpu_req  = 1'b1;
        for (int k = 1; k <= 400 && !found; k++) begin
            tick();
            found = ovr_v[2];
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL overrun_rise: got 0 after 400 cycles, expected 1");
        end
        for (int k = 0; k < 50; k++) begin
            tick();
            if (ovr_v[2] !== 1'b1) drops++;
        end
        tests_run++;
        if (drops != 0) begin
            tests_failed++;
            $display("FAIL overrun_sticky: got %0d cycles low, expected 0", drops);
        end
        tests_run++;
        if (ovr_v[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_spurious: got %b on short-CAS instance, expected 0", ovr_v[1]);
        end
        cpu_req = 1'b0;
        RESET   = 1'b1;
        tick();
        RESET   = 1'b0;
        tests_run++;
        if (ovr_v[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_clear: got %b, expected 0", ovr_v[2]);
        end
    endtask

    task automatic test_reset_mid_cas();
        exp_t e;
        bit   found = 1'b0;
        int   ack_k = 0;
        do_reset();
        dma_addr = 18'h1F0F0;
        dma_we   = 1'b0;
        sb.push_back('{is_dma: 1'b1, row: row_of(dma_addr), col: col_of(dma_addr), we: 1'b0});
        dma_req  = 1'b1;
        repeat (4) tick();
        tests_run++;
        if (strobes(0) !== 5'b01001) begin
            tests_failed++;
            $display("FAIL mid_cas_read: got %b, expected 01001", strobes(0));
        end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tests_run++;
        if ({strobes(0), dma_ack_v[0], cpu_ack_v[0]} !== {S_IDLE, 2'b00}) begin
            tests_failed++;
            $display("FAIL mid_cas_reset: got %b ack=%b, expected %b ack=00",
                     strobes(0), {dma_ack_v[0], cpu_ack_v[0]}, S_IDLE);
        end
        tests_run++;
        if ({row_v[0], col_v[0]} !== '0) begin
            tests_failed++;
            $display("FAIL mid_cas_addr: got %h/%h, expected 0/0", row_v[0], col_v[0]);
        end
        tick();
        tests_run++;
        if (strobes(0) !== 5'b00111) begin
            tests_failed++;
            $display("FAIL mid_cas_regrant: got %b, expected 00111", strobes(0));
        end
        for (int k = 7; k <= 30 && !found; k++) begin
            tick();
            if (cpu_ack_v[0] || dma_ack_v[0]) begin
                found = 1'b1;
                ack_k = k;
                dma_req = 1'b0;
                e = sb.pop_front();
                tests_run++;
                if ({dma_ack_v[0], row_v[0], col_v[0], nWE_v[0]} !== {e.is_dma, e.row, e.col, ~e.we}) begin
                    tests_failed++;
                    $display("FAIL mid_cas_ack: got %b %h/%h/%b, expected %b %h/%h/%b",
                             dma_ack_v[0], row_v[0], col_v[0], nWE_v[0], e.is_dma, e.row, e.col, ~e.we);
                end
            end
        end
        tests_run++;
        if (!found || ack_k != 10) begin
            tests_failed++;
            $display("FAIL mid_cas_ack_cycle: got %0d (found=%0b), expected 10", ack_k, found);
        end
        dma_req = 1'b0;
    endtask

    task automatic test_short_access();
        int   starts [$];
        int   acks [$];
        int   nwe_bad = 0;
        bit   re_cpu = 1'b0;
        logic prev_oe = 1'b1;
        do_reset();
        cpu_addr = 18'h155AA;
        cpu_we   = 1'b0;
        cpu_req  = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (re_cpu) begin cpu_req = 1'b1; re_cpu = 1'b0; end
            if (nWE_v[3] !== 1'b1) nwe_bad++;
            if (prev_oe && !mux_nOE_v[3]) starts.push_back(k);
            prev_oe = mux_nOE_v[3];
            if (cpu_ack_v[3]) begin
                acks.push_back(k);
                cpu_req = 1'b0;
                if (acks.size() == 1) re_cpu = 1'b1;
            end
        end
        tests_run++;
        if (acks.size() < 1 || acks[0] != 4) begin
            tests_failed++;
            $display("FAIL short_ack: got %0d acks (first %0d), expected first at 4",
                     acks.size(), (acks.size() > 0) ? acks[0] : -1);
        end
        tests_run++;
        if (starts.size() != 2 || starts[1] - starts[0] != 6) begin
            tests_failed++;
            $display("FAIL short_period: got %0d starts (gap %0d), expected 2 (gap 6)",
                     starts.size(), (starts.size() > 1) ? starts[1] - starts[0] : -1);
        end
        tests_run++;
        if (nwe_bad != 0) begin
            tests_failed++;
            $display("FAIL short_nwe: got %0d cycles low, expected 0", nwe_bad);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_back_to_back();
        test_refresh();
        test_overrun();
        test_reset_mid_cas();
        test_short_access();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
